multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle CPU datapath.
//  - Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK over several clocks.
//  - Supports R-type, addi, lw, sw, beq and j.
//  - Stalls on a memory ready handshake; traps on an illegal opcode or a memory timeout.
//  - Sits between the instruction register opcode field and the datapath muxes, enables and ALU control.
// PARAMETERS
//  TIMEOUT   16  max cycles to wait for mem_ready_i in a memory state; 0 disables timeout
//  CNT_W     5   wait-counter width; must hold TIMEOUT
// PORTS
//  clk_i          in   1  clock, rising edge
//  rst_n_i        in   1  reset, asynchronous, active-low
//  Op_i           in   6  opcode, IR[31:26]; valid from DECODE onward
//  Zero_i         in   1  ALU zero flag (for beq)
//  mem_ready_i    in   1  memory completes the current access this cycle
//  PCWrite_o      out  1  unconditional PC load
//  PCWriteCond_o  out  1  PC load if Zero_i
//  IorD_o         out  1  memory address source: 0 = PC, 1 = ALUOut
//  MemRead_o      out  1  memory read request
//  MemWrite_o     out  1  memory write request
//  IRWrite_o      out  1  IR load
//  MemtoReg_o     out  1  register-file write data: 1 = MDR, 0 = ALUOut
//  RegDst_o       out  1  destination register: 1 = rd, 0 = rt
//  RegWrite_o     out  1  register-file write enable
//  ALUSrcA_o      out  1  ALU A input: 0 = PC, 1 = A register
//  ALUSrcB_o      out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
//  ALUOp_o        out  2  ALU op: 00 = add, 01 = sub, 10 = funct
//  PCSource_o     out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//  trap_o         out  1  sticky; set in TRAP state
//  trap_cause_o   out  2  trap cause: 01 = illegal opcode, 10 = memory timeout
//  state_o        out  4  current state code (debug)
// BEHAVIOUR
//  States and codes, with their transitions:
//   RST=0 -> FETCH
//   FETCH=1: MemRead=1, ALUSrcB=01, ALUOp=00. Waits for mem_ready_i; on ready pulses IRWrite and PCWrite, then -> DECODE.
//   DECODE=2: ALUSrcB=11, ALUOp=00 (branch target). Next state by opcode:
//    000000 -> REXE;  001000 -> IEXE;  100011 / 101011 -> MADR;  000100 -> BEQ;  000010 -> JMP;  any other -> TRAP(01).
//   REXE=3: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB
//   RWB=4: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH
//   IEXE=5: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IWB
//   IWB=6: RegDst=0, RegWrite=1, MemtoReg=0 -> FETCH
//   MADR=7: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MRD if Op=lw, MWR if Op=sw.
//   MRD=8: IorD=1, MemRead=1; on ready -> MWB
//   MWB=9: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH
//   MWR=10: IorD=1, MemWrite=1; on ready -> FETCH
//   BEQ=11: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1 -> FETCH
//   JMP=12: PCSource=10, PCWrite=1 -> FETCH
//   TRAP=15: all enables 0, trap_o=1. Held until reset.
//  Output timing:
//   - Outputs are a Moore decode of the registered state.
//   - Exceptions: FETCH IRWrite_o and PCWrite_o = mem_ready_i (Mealy), so the IR/PC load happens in the ready cycle only.
//   - Any output not listed for a state is 0.
//  Latency with zero memory wait:
//   - R-type / addi / sw: 4 cycles
//   - lw: 5 cycles
//   - beq / j: 3 cycles
//   - Each memory wait cycle adds 1.
//  Wait counter:
//   - Cleared on entry to FETCH, MRD or MWR.
//   - Increments each cycle in those states while mem_ready_i=0.
//   - If TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ready_i still 0 -> TRAP(10).
//   - mem_ready_i=1 in the same cycle the counter hits TIMEOUT: ready wins, no trap.
//  Reset:
//   - rst_n_i low forces RST immediately (also mid-instruction, also from TRAP).
//   - In RST every output is 0, including trap_o, trap_cause_o and state_o=0.
//   - First FETCH occurs in the first cycle after rst_n_i rises.
//  Boundary conditions:
//   - Op_i is sampled only in DECODE and MADR; changes elsewhere are ignored.
//   - mem_ready_i is ignored outside FETCH/MRD/MWR.
//   - Unused state codes 13/14 -> TRAP(01).
// TESTING
//  1. Reset released, mem_ready_i=1, Op=000000
//     -> state_o 1,2,3,4,1; RegWrite=1 only in RWB with RegDst=1; IRWrite=1 in FETCH only.
//  2. lw (100011), ready after 2 wait cycles in both FETCH and MRD
//     -> 9 cycles FETCH->FETCH; MemRead=1 and IorD=1 throughout MRD; MemtoReg=1 and RegWrite=1 in MWB.
//  3. beq (000100) with Zero_i=1, then again with Zero_i=0
//     -> PCWriteCond=1, PCSource=01, ALUOp=01 in BEQ in both runs; 3 cycles each.
//  4. Op=111111 in DECODE
//     -> TRAP next cycle, trap_o=1, trap_cause=01, all enables 0; holds 10 cycles; rst_n_i low clears it.
//  5. TIMEOUT=16, sw (101011) with mem_ready_i stuck 0 in MWR
//     -> TRAP with cause 10 after 16 wait cycles; repeat with ready on cycle 16 -> no trap, back to FETCH.
//  6. rst_n_i pulsed low mid-MRD, asynchronously between clock edges
//     -> state_o=0 and all outputs 0 immediately; FETCH on the first edge after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle CPU datapath: sequences fetch/decode/execute/
// memory/writeback, stalls on the memory ready handshake and traps on illegal opcodes or timeouts.
`timescale 1ns/1ps
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [5:0] Op_i,
  input  logic       Zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_REXE   = 4'd3,
    S_RWB    = 4'd4,
    S_IEXE   = 4'd5,
    S_IWB    = 4'd6,
    S_MADR   = 4'd7,
    S_MRD    = 4'd8,
    S_MWB    = 4'd9,
    S_MWR    = 4'd10,
    S_BEQ    = 4'd11,
    S_JMP    = 4'd12,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;
  logic             unused_zero;

  // The zero flag gates the PC load inside the datapath; the FSM only raises PCWriteCond.
  assign unused_zero = Zero_i;

  // A trap fires when this not-ready cycle would bring the counter up to TIMEOUT.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    cause_d       = cause_q;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    PCSource_o    = 2'b00;
    trap_o        = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (Op_i)
          OP_RTYPE:      state_d = S_REXE;
          OP_ADDI:       state_d = S_IEXE;
          OP_LW, OP_SW:  state_d = S_MADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_J:          state_d = S_JMP;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_REXE: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
        state_d   = S_RWB;
      end

      S_RWB: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end

      S_IEXE: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = S_IWB;
      end

      S_IWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end

      S_MADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        if (Op_i == OP_LW) begin
          state_d = S_MRD;
        end else if (Op_i == OP_SW) begin
          state_d = S_MWR;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end

      S_MRD: begin
        IorD_o    = 1'b1;
        MemRead_o = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MWB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_MWB: begin
        MemtoReg_o = 1'b1;
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end

      S_MWR: begin
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_BEQ: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCSource_o    = 2'b01;
        PCWriteCond_o = 1'b1;
        state_d       = S_FETCH;
      end

      S_JMP: begin
        PCSource_o = 2'b10;
        PCWrite_o  = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: trap_o = 1'b1;

      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random instruction
// streams compared cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [5:0] Op_i = '0;
  logic       Zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, trap_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o, trap_cause_o;
  logic [3:0] state_o;

  multicycle_control #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .Op_i(Op_i), .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
  } obs_t;

  typedef enum {P_FETCH, P_DECODE, P_REXE, P_RWB, P_IEXE, P_IWB, P_MADR, P_MRD,
                P_MWB, P_MWR, P_BEQ, P_JMP, P_TRAP} phase_e;

  typedef struct {
    phase_e     ph;
    logic       rdy;
    logic [5:0] op;
    logic       zero;
    obs_t       exp;
  } cyc_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;

  obs_t obs;
  assign obs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
                PCSource_o, trap_o, trap_cause_o, state_o};

  int   tests = 0;
  int   fails = 0;
  cyc_t q[$];

  // Control table straight from the state descriptions; anything unlisted stays 0.
  function automatic obs_t phase_obs(phase_e p, logic rdy, logic [1:0] cause);
    obs_t o;
    o = '0;
    case (p)
      P_FETCH:  begin o.state = 4'd1;  o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                      o.ir_write = rdy; o.pc_write = rdy; end
      P_DECODE: begin o.state = 4'd2;  o.alu_src_b = 2'b11; end
      P_REXE:   begin o.state = 4'd3;  o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      P_RWB:    begin o.state = 4'd4;  o.reg_dst = 1'b1; o.reg_write = 1'b1; end
      P_IEXE:   begin o.state = 4'd5;  o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      P_IWB:    begin o.state = 4'd6;  o.reg_write = 1'b1; end
      P_MADR:   begin o.state = 4'd7;  o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      P_MRD:    begin o.state = 4'd8;  o.iord = 1'b1; o.mem_read = 1'b1; end
      P_MWB:    begin o.state = 4'd9;  o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      P_MWR:    begin o.state = 4'd10; o.iord = 1'b1; o.mem_write = 1'b1; end
      P_BEQ:    begin o.state = 4'd11; o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                      o.pc_source = 2'b01; o.pc_write_cond = 1'b1; end
      P_JMP:    begin o.state = 4'd12; o.pc_source = 2'b10; o.pc_write = 1'b1; end
      P_TRAP:   begin o.state = 4'd15; o.trap = 1'b1; o.trap_cause = cause; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input obs_t exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, obs, exp,
             obs.state, exp.state);
    end
  endtask

  // Cycles where the FSM ignores an input get random values for it.
  task automatic push(input phase_e p, input logic rdy, input logic [5:0] op,
                      input logic [1:0] cause);
    cyc_t c;
    c.ph   = p;
    c.rdy  = rdy;
    c.op   = op;
    c.zero = 1'($urandom);
    c.exp  = phase_obs(p, rdy, cause);
    q.push_back(c);
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_rdy();
    return 1'($urandom);
  endfunction

  // One instruction from FETCH back to the next FETCH, with the given memory wait counts.
  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(P_FETCH, 1'b0, rnd_op(), 2'b00);
    push(P_FETCH, 1'b1, rnd_op(), 2'b00);
    push(P_DECODE, rnd_rdy(), op, 2'b00);
    case (op)
      OP_R:    begin push(P_REXE, rnd_rdy(), rnd_op(), 2'b00); push(P_RWB, rnd_rdy(), rnd_op(), 2'b00); end
      OP_ADDI: begin push(P_IEXE, rnd_rdy(), rnd_op(), 2'b00); push(P_IWB, rnd_rdy(), rnd_op(), 2'b00); end
      OP_LW: begin
        push(P_MADR, rnd_rdy(), op, 2'b00);
        for (int i = 0; i < mw; i++) push(P_MRD, 1'b0, rnd_op(), 2'b00);
        push(P_MRD, 1'b1, rnd_op(), 2'b00);
        push(P_MWB, rnd_rdy(), rnd_op(), 2'b00);
      end
      OP_SW: begin
        push(P_MADR, rnd_rdy(), op, 2'b00);
        for (int i = 0; i < mw; i++) push(P_MWR, 1'b0, rnd_op(), 2'b00);
        push(P_MWR, 1'b1, rnd_op(), 2'b00);
      end
      OP_BEQ:  push(P_BEQ, rnd_rdy(), rnd_op(), 2'b00);
      OP_J:    push(P_JMP, rnd_rdy(), rnd_op(), 2'b00);
      default: push(P_TRAP, rnd_rdy(), rnd_op(), 2'b01);
    endcase
  endtask

  // Entered at posedge+1; inputs applied, outputs checked 1 ns later, then on to the next cycle.
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      Op_i        = c.op;
      mem_ready_i = c.rdy;
      Zero_i      = c.zero;
      #1;
      check(c.exp, c.ph.name());
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asynchronous reset from mid-cycle; ends at posedge+1 with the DUT in FETCH.
  task automatic do_reset(input string tag);
    #2;
    rst_n_i     = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    check('0, {tag, "_rst_async"});
    @(negedge clk_i);
    #1;
    check('0, {tag, "_rst_held"});
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit is_legal(logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int         n;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};

    // Reset state and first FETCH after release.
    mem_ready_i = 1'b1;
    #3;
    check('0, "reset_state");
    @(posedge clk_i);
    #1;
    check('0, "reset_state_clocked");
    do_reset("init");

    // R-type with zero wait: 1,2,3,4 then FETCH.
    gen_instr(OP_R, 0, 0);
    play();
    // lw with 2 wait cycles in FETCH and MRD: 9 cycles.
    gen_instr(OP_LW, 2, 2);
    play();
    // beq twice with both Zero_i values; control output does not depend on it.
    gen_instr(OP_BEQ, 0, 0);
    q[q.size()-1].zero = 1'b1;
    play();
    gen_instr(OP_BEQ, 0, 0);
    q[q.size()-1].zero = 1'b0;
    play();
    gen_instr(OP_J, 1, 0);
    gen_instr(OP_ADDI, 0, 0);
    gen_instr(OP_SW, 0, 1);
    play();

    // Illegal opcode: trap for 10 cycles, then reset clears it.
    gen_instr(6'b111111, 0, 0);
    for (int i = 0; i < 9; i++) push(P_TRAP, rnd_rdy(), rnd_op(), 2'b01);
    play();
    do_reset("illegal");

    // sw with ready stuck low: trap after 16 wait cycles.
    push(P_FETCH, 1'b1, rnd_op(), 2'b00);
    push(P_DECODE, 1'b0, OP_SW, 2'b00);
    push(P_MADR, 1'b0, OP_SW, 2'b00);
    for (int i = 0; i < 16; i++) push(P_MWR, 1'b0, rnd_op(), 2'b00);
    for (int i = 0; i < 3; i++) push(P_TRAP, rnd_rdy(), rnd_op(), 2'b10);
    play();
    do_reset("timeout");

    // Ready arriving on the 16th wait cycle wins: no trap.
    gen_instr(OP_SW, 0, 15);
    gen_instr(OP_R, 15, 0);
    gen_instr(OP_LW, 0, 15);
    play();

    // Fetch-side timeout.
    for (int i = 0; i < 16; i++) push(P_FETCH, 1'b0, rnd_op(), 2'b00);
    push(P_TRAP, 1'b1, rnd_op(), 2'b10);
    play();
    do_reset("fetch_timeout");

    // Reset pulsed mid-MRD.
    push(P_FETCH, 1'b1, rnd_op(), 2'b00);
    push(P_DECODE, 1'b1, OP_LW, 2'b00);
    push(P_MADR, 1'b1, OP_LW, 2'b00);
    push(P_MRD, 1'b0, rnd_op(), 2'b00);
    push(P_MRD, 1'b0, rnd_op(), 2'b00);
    play();
    mem_ready_i = 1'b0;
    #1;
    check(phase_obs(P_MRD, 1'b0, 2'b00), "mrd_before_reset");
    do_reset("mid_mrd");

    // Random instruction stream, with occasional illegal opcodes followed by a reset.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd_op(); while (is_legal(op));
        gen_instr(op, $urandom_range(0, 3), 0);
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) push(P_TRAP, rnd_rdy(), rnd_op(), 2'b01);
        play();
        do_reset("rand_illegal");
      end else begin
        gen_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
        play();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
